// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter.
//   state_t         : access sequencer states (IDLE/SETUP/STROBE/DONE)
//   GNT_SNES/GNT_AVR: grant index constants
//   WAIT_MIN/WAIT_MAX: legal range of strobe-active cycles per access
//   wait_count_load : converts a wait-cycle count into the STROBE counter preload
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic GNT_SNES = 1'b0;
    localparam logic GNT_AVR  = 1'b1;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;

    // The STROBE counter runs from cycles-1 down to 0. Out-of-range values are
    // clamped so a bad parameter still yields a working (if mistimed) bus.
    function automatic logic [WAIT_W-1:0] wait_count_load(input int cycles);
        int c;
        c = cycles;
        if (c < WAIT_MIN) c = WAIT_MIN;
        if (c > WAIT_MAX) c = WAIT_MAX;
        return WAIT_W'(c - 1);
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bundle of requester handshakes and SRAM pin signals for sram_bus_arbiter.
//   slave  modport : the arbiter (takes requests + sram_din, drives acks/rdata/SRAM strobes)
//   master modport : the surrounding requesters and SRAM model
// Parameters: ADDR_W (SRAM address width), DATA_W (SRAM data width).
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    logic              snes_req;
    logic              snes_we;
    logic [ADDR_W-1:0] snes_addr;
    logic [DATA_W-1:0] snes_wdata;
    logic [DATA_W-1:0] snes_rdata;
    logic              snes_ack;

    logic              avr_req;
    logic              avr_we;
    logic [ADDR_W-1:0] avr_addr;
    logic [DATA_W-1:0] avr_wdata;
    logic [DATA_W-1:0] avr_rdata;
    logic              avr_ack;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] sram_din;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              busy;

    modport slave (
        input  snes_req, snes_we, snes_addr, snes_wdata,
        input  avr_req, avr_we, avr_addr, avr_wdata,
        input  sram_din,
        output snes_rdata, snes_ack, avr_rdata, avr_ack,
        output sram_addr, sram_dout, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy
    );

    modport master (
        output snes_req, snes_we, snes_addr, snes_wdata,
        output avr_req, avr_we, avr_addr, avr_wdata,
        output sram_din,
        input  snes_rdata, snes_ack, avr_rdata, avr_ack,
        input  sram_addr, sram_dout, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy
    );
endinterface

// File: rtl/sram_strobe_gen.sv
// Access sequencer: IDLE -> SETUP -> STROBE (load_val+1 cycles) -> DONE -> IDLE.
// Ports:
//   avr_clk, avr_reset_n : clock, synchronous active-low reset
//   start                : begin an access (honoured only in IDLE)
//   we                   : 1=write, sampled with start
//   load_val             : STROBE counter preload (wait cycles - 1)
//   ce_n/oe_n/we_n/dq_oe : registered SRAM strobes
//   capture              : high during the last STROBE cycle (read data valid at its edge)
//   done                 : high during DONE
//   busy                 : high whenever not IDLE
module sram_strobe_gen
    import sram_arb_pkg::*;
(
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              start,
    input  logic              we,
    input  logic [WAIT_W-1:0] load_val,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              dq_oe,
    output logic              capture,
    output logic              done,
    output logic              busy
);
    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              dq_oe_reg, dq_oe_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP;
                    we_next    = we;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
                cnt_next   = load_val;
            end
            ST_STROBE: begin
                if (cnt_reg == '0) state_next = ST_DONE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        // Strobes are decoded from the state being entered and registered,
        // so the SRAM pins never see decode glitches.
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        case (state_next)
            ST_SETUP: begin
                ce_n_next  = 1'b0;
                oe_n_next  = we_next;
                dq_oe_next = we_next;
            end
            ST_STROBE: begin
                ce_n_next  = 1'b0;
                oe_n_next  = we_next;
                we_n_next  = ~we_next;
                dq_oe_next = we_next;
            end
            ST_DONE: begin
                // Data hold: ce_n and the data drive outlast the strobes by one cycle.
                ce_n_next  = 1'b0;
                dq_oe_next = we_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge avr_clk) begin
        if (!avr_reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            dq_oe_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            dq_oe_reg <= dq_oe_next;
        end
    end

    assign ce_n    = ce_n_reg;
    assign oe_n    = oe_n_reg;
    assign we_n    = we_n_reg;
    assign dq_oe   = dq_oe_reg;
    assign capture = (state_reg == ST_STROBE) && (cnt_reg == '0);
    assign done    = (state_reg == ST_DONE);
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one external SRAM between the SNES cartridge port and the AVR port.
// Fixed priority SNES over AVR; one access at a time, sequenced by sram_strobe_gen.
// Ports:
//   avr_clk      : system clock, rising edge
//   avr_reset_n  : synchronous active-low reset (aborts any access, no ack)
//   bus          : sram_bus_arbiter_if.slave (requests, acks, rdata, SRAM pins, busy)
// Parameters: ADDR_W, DATA_W, WAIT_CYCLES (1..15 strobe cycles),
//   MAX_WAIT (AVR starvation limit, present only with ARB_STARVE_GUARD_EN).
// Build option: define ARB_STARVE_GUARD_EN to force an AVR grant after MAX_WAIT
//   consecutive SNES grants won against a pending AVR request.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT    = 8
`endif
) (
    input logic              avr_clk,
    input logic              avr_reset_n,
    sram_bus_arbiter_if.slave bus
);
    logic              start, avr_wins;
    logic              capture, done, busy;
    logic              ce_n, oe_n, we_n, dq_oe;
    logic              grant_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] snes_rdata_reg, avr_rdata_reg;

    // A request seen while idle always starts an access; back-to-back is normal.
    assign start = !busy && (bus.snes_req || bus.avr_req);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_reg;

    assign avr_wins = bus.avr_req && (!bus.snes_req || (starve_reg >= 4'(MAX_WAIT)));

    always_ff @(posedge avr_clk) begin
        if (!avr_reset_n) begin
            starve_reg <= '0;
        end else if (start) begin
            if (avr_wins)
                starve_reg <= '0;
            else if (bus.avr_req && starve_reg != 4'hF)
                starve_reg <= starve_reg + 4'd1;
        end
    end
`else
    assign avr_wins = bus.avr_req && !bus.snes_req;
`endif

    always_ff @(posedge avr_clk) begin
        if (!avr_reset_n) begin
            grant_reg      <= GNT_SNES;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            snes_rdata_reg <= '0;
            avr_rdata_reg  <= '0;
        end else begin
            // Winner's request is frozen here; later input changes are ignored.
            if (start) begin
                grant_reg <= avr_wins ? GNT_AVR : GNT_SNES;
                we_reg    <= avr_wins ? bus.avr_we    : bus.snes_we;
                addr_reg  <= avr_wins ? bus.avr_addr  : bus.snes_addr;
                wdata_reg <= avr_wins ? bus.avr_wdata : bus.snes_wdata;
            end
            if (capture && !we_reg) begin
                if (grant_reg == GNT_AVR) avr_rdata_reg  <= bus.sram_din;
                else                      snes_rdata_reg <= bus.sram_din;
            end
        end
    end

    sram_strobe_gen u_strobe (
        .avr_clk     (avr_clk),
        .avr_reset_n (avr_reset_n),
        .start       (start),
        .we          (avr_wins ? bus.avr_we : bus.snes_we),
        .load_val    (wait_count_load(WAIT_CYCLES)),
        .ce_n        (ce_n),
        .oe_n        (oe_n),
        .we_n        (we_n),
        .dq_oe       (dq_oe),
        .capture     (capture),
        .done        (done),
        .busy        (busy)
    );

    assign bus.sram_addr  = addr_reg;
    assign bus.sram_dout  = wdata_reg;
    assign bus.sram_ce_n  = ce_n;
    assign bus.sram_oe_n  = oe_n;
    assign bus.sram_we_n  = we_n;
    assign bus.sram_dq_oe = dq_oe;
    assign bus.busy       = busy;
    assign bus.snes_rdata = snes_rdata_reg;
    assign bus.avr_rdata  = avr_rdata_reg;
    assign bus.snes_ack   = done && (grant_reg == GNT_SNES);
    assign bus.avr_ack    = done && (grant_reg == GNT_AVR);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter with a 256-byte SRAM model
// (indexed by sram_addr[7:0]) and per-requester expectation queues.
module tb_sram_bus_arbiter;
    localparam int ADDR_W      = 21;
    localparam int DATA_W      = 8;
    localparam int WAIT_CYCLES = 2;

    logic avr_clk = 1'b0;
    logic avr_reset_n;
    always #5 avr_clk = ~avr_clk;

    sram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .avr_clk     (avr_clk),
        .avr_reset_n (avr_reset_n),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // SRAM model: reset loads mem[i]=i; writes land while ce_n, we_n low and data driven.
    logic [7:0] sram_mem [256];
    always @(posedge avr_clk) begin
        if (!avr_reset_n) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 8'(i);
        end else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            sram_mem[bus.sram_addr[7:0]] <= bus.sram_dout;
        end
    end
    assign bus.sram_din = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[7:0]] : 8'h00;

    // Bench-side expectation of memory contents.
    logic [7:0] model_mem [256];

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } exp_t;
    exp_t snes_q[$];
    exp_t avr_q[$];
    bit   sb_on = 1'b1;

    always @(negedge avr_clk) begin
        exp_t e;
        if (sb_on && bus.snes_ack) begin
            if (snes_q.size() == 0) begin
                check("snes_unexpected_ack", 1, 0);
            end else begin
                e = snes_q.pop_front();
                $display("snes ack we=%0d rdata=0x%02h", e.we, bus.snes_rdata);
                if (!e.we) check("snes_rdata", bus.snes_rdata, e.data);
            end
        end
        if (sb_on && bus.avr_ack) begin
            if (avr_q.size() == 0) begin
                check("avr_unexpected_ack", 1, 0);
            end else begin
                e = avr_q.pop_front();
                $display("avr ack we=%0d rdata=0x%02h", e.we, bus.avr_rdata);
                if (!e.we) check("avr_rdata", bus.avr_rdata, e.data);
            end
        end
    end

    // One access; k counts rising edges from the sampling edge to the edge at which
    // the requester sees ack (ack is observed on the negedge just before that edge).
    task automatic do_access(input string name, input bit is_avr, input bit we,
                             input logic [20:0] addr, input logic [7:0] wdata);
        int          k;
        int          we_low;
        int          dq_cnt;
        bit          got;
        logic        busy_setup;
        logic [20:0] seen_addr;
        logic [7:0]  seen_dout;
        exp_t        e;
        k = 0; we_low = 0; dq_cnt = 0; got = 0; busy_setup = 0;
        seen_addr = '0; seen_dout = '0;
        e.we   = we;
        e.data = we ? wdata : model_mem[addr[7:0]];
        if (we) model_mem[addr[7:0]] = wdata;
        if (is_avr) begin
            avr_q.push_back(e);
            bus.avr_we = we; bus.avr_addr = addr; bus.avr_wdata = wdata; bus.avr_req = 1'b1;
        end else begin
            snes_q.push_back(e);
            bus.snes_we = we; bus.snes_addr = addr; bus.snes_wdata = wdata; bus.snes_req = 1'b1;
        end
        while (!got && k < 40) begin
            @(posedge avr_clk);
            k++;
            @(negedge avr_clk);
            if (k == 1) busy_setup = bus.busy;
            if (!bus.sram_we_n) we_low++;
            if (bus.sram_dq_oe) begin
                dq_cnt++;
                seen_dout = bus.sram_dout;
            end
            if (!bus.sram_ce_n) seen_addr = bus.sram_addr;
            got = is_avr ? bus.avr_ack : bus.snes_ack;
        end
        if (is_avr) bus.avr_req = 1'b0;
        else        bus.snes_req = 1'b0;
        $display("%s: %s addr=0x%06h latency=%0d", name, we ? "write" : "read", addr, k);
        check({name, "_latency"}, got ? k : 0, WAIT_CYCLES + 2);
        check({name, "_busy"}, busy_setup, 1);
        check({name, "_we_n_low"}, we_low, we ? WAIT_CYCLES : 0);
        check({name, "_dq_oe_cycles"}, dq_cnt, we ? WAIT_CYCLES + 2 : 0);
        check({name, "_sram_addr"}, seen_addr, addr);
        if (we) check({name, "_sram_dout"}, seen_dout, wdata);
        @(posedge avr_clk);
        @(negedge avr_clk);
    endtask

    initial begin
        int k, ks, ka, sn, av, acks;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i);
        avr_reset_n    = 1'b0;
        bus.snes_req   = 1'b0; bus.snes_we = 1'b0; bus.snes_addr = '0; bus.snes_wdata = '0;
        bus.avr_req    = 1'b0; bus.avr_we  = 1'b0; bus.avr_addr  = '0; bus.avr_wdata  = '0;

        // Reset state
        repeat (2) @(posedge avr_clk);
        @(negedge avr_clk);
        check("rst_ce_n", bus.sram_ce_n, 1);
        check("rst_oe_n", bus.sram_oe_n, 1);
        check("rst_we_n", bus.sram_we_n, 1);
        check("rst_dq_oe", bus.sram_dq_oe, 0);
        check("rst_acks", {bus.snes_ack, bus.avr_ack}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_rdata", {bus.snes_rdata, bus.avr_rdata}, 0);
        avr_reset_n = 1'b1;
        @(negedge avr_clk);

        // Single accesses, including the top of the address range
        do_access("avr_rd_aa",    1'b1, 1'b0, 21'h0000AA, 8'h00);
        do_access("avr_wr_top",   1'b1, 1'b1, 21'h1FFFFF, 8'hEE);
        do_access("snes_rd_top",  1'b0, 1'b0, 21'h1FFFFF, 8'h00);
        do_access("snes_wr_55",   1'b0, 1'b1, 21'h000055, 8'h3C);
        do_access("avr_rd_55",    1'b1, 1'b0, 21'h000055, 8'h00);
        do_access("snes_rd_40",   1'b0, 1'b0, 21'h100040, 8'h00);

        // Simultaneous requests: SNES first, AVR one full access later
        snes_q.push_back('{we: 1'b0, data: model_mem[8'h22]});
        avr_q.push_back('{we: 1'b0, data: model_mem[8'h33]});
        bus.snes_we = 1'b0; bus.snes_addr = 21'h000022;
        bus.avr_we  = 1'b0; bus.avr_addr  = 21'h000033;
        bus.snes_req = 1'b1; bus.avr_req = 1'b1;
        k = 0; ks = 0; ka = 0;
        while (ka == 0 && k < 60) begin
            @(posedge avr_clk);
            k++;
            @(negedge avr_clk);
            if (bus.snes_ack && ks == 0) begin ks = k; bus.snes_req = 1'b0; end
            if (bus.avr_ack) begin ka = k; bus.avr_req = 1'b0; end
        end
        bus.snes_req = 1'b0; bus.avr_req = 1'b0;
        $display("simul: snes ack at %0d, avr ack at %0d", ks, ka);
        check("simul_snes_latency", ks, WAIT_CYCLES + 2);
        check("simul_avr_gap", ka - ks, WAIT_CYCLES + 3);
        @(posedge avr_clk);
        @(negedge avr_clk);
        check("sb_drained", snes_q.size() + avr_q.size(), 0);

        // Reset during STROBE of an SNES write: no ack, strobes released, rdata cleared
        bus.snes_we = 1'b1; bus.snes_addr = 21'h000100; bus.snes_wdata = 8'h5A; bus.snes_req = 1'b1;
        @(posedge avr_clk);
        @(posedge avr_clk);
        @(negedge avr_clk);
        check("abort_in_strobe_we_n", bus.sram_we_n, 0);
        avr_reset_n = 1'b0;
        bus.snes_req = 1'b0;
        @(posedge avr_clk);
        @(negedge avr_clk);
        check("abort_ce_n", bus.sram_ce_n, 1);
        check("abort_we_n", bus.sram_we_n, 1);
        check("abort_oe_n", bus.sram_oe_n, 1);
        check("abort_dq_oe", bus.sram_dq_oe, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_snes_rdata", bus.snes_rdata, 0);
        acks = 0;
        @(posedge avr_clk);
        @(negedge avr_clk);
        avr_reset_n = 1'b1;
        repeat (8) begin
            @(posedge avr_clk);
            @(negedge avr_clk);
            if (bus.snes_ack) acks++;
        end
        $display("abort: %0d acks after reset", acks);
        check("abort_no_ack", acks, 0);

        // Starvation: both requests held high continuously
        sb_on = 1'b0;
        bus.snes_we = 1'b0; bus.snes_addr = 21'h000010;
        bus.avr_we  = 1'b0; bus.avr_addr  = 21'h000020;
        bus.snes_req = 1'b1; bus.avr_req = 1'b1;
        sn = 0; av = 0; k = 0;
        while (av == 0 && sn < 12 && k < 200) begin
            @(posedge avr_clk);
            k++;
            @(negedge avr_clk);
            if (bus.snes_ack) sn++;
            if (bus.avr_ack)  av++;
        end
        bus.snes_req = 1'b0; bus.avr_req = 1'b0;
        $display("starve: %0d snes grants, %0d avr grants", sn, av);
`ifdef ARB_STARVE_GUARD_EN
        check("guard_snes_before_avr", sn, 8);
        check("guard_avr_granted", av, 1);
`else
        check("strict_snes_grants", sn, 12);
        check("strict_avr_starved", av, 0);
`endif
        repeat (10) @(posedge avr_clk);
        @(negedge avr_clk);
        check("final_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
